flash_sample_reader: RTL and testbench

Reads 32-bit words from the on-board flash over its Avalon-MM read port and streams them as 16-bit audio samples, low half first, one sample per `sample_tick`. It is the consumer end of the flash address counter. It reads `address_in` from the counter, performs the flash read, and pulses `get_address` once per completed word so the counter advances and wraps. Its output feeds the audio output path.

---
 rtl/flash_sample_reader_if.sv | 22 ++
 rtl/flash_sample_reader.sv | 96 +++++++++
 tb/tb_flash_sample_reader.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_sample_reader_if.sv
// Avalon-MM read-only port between flash_sample_reader (master) and the flash controller (slave).
interface flash_sample_reader_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output read, address, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, address, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/flash_sample_reader.sv
// Fetches one 32-bit flash word per address-counter step and plays it out as two
// 16-bit samples (low half first), one per sample_tick while play is high.
module flash_sample_reader #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 play,
  input  logic                 sample_tick,
  input  logic [ADDR_W-1:0]    address_in,
  output logic                 get_address,
  flash_sample_reader_if.master flash_mem,
  output logic [15:0]          audio_data,
  output logic                 audio_valid
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    OUT_LO,
    OUT_HI
  } state_t;

  state_t            state_reg;
  logic              read_reg;
  logic [ADDR_W-1:0] address_reg;
  logic [DATA_W-1:0] word_reg;
  logic              get_address_reg;
  logic [15:0]       audio_data_reg;
  logic              audio_valid_reg;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      read_reg        <= 1'b0;
      address_reg     <= '0;
      word_reg        <= '0;
      get_address_reg <= 1'b0;
      audio_data_reg  <= '0;
      audio_valid_reg <= 1'b0;
    end else begin
      get_address_reg <= 1'b0;
      audio_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (play) begin
            address_reg <= address_in;
            read_reg    <= 1'b1;
            state_reg   <= REQ;
          end
        end
        // A started read always runs to completion, even if play drops meanwhile.
        REQ: begin
          if (!flash_mem.waitrequest) begin
            read_reg  <= 1'b0;
            state_reg <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (flash_mem.readdatavalid) begin
            word_reg        <= flash_mem.readdata;
            get_address_reg <= 1'b1;
            state_reg       <= OUT_LO;
          end
        end
        OUT_LO: begin
          if (sample_tick && play) begin
            audio_data_reg  <= word_reg[15:0];
            audio_valid_reg <= 1'b1;
            state_reg       <= OUT_HI;
          end
        end
        OUT_HI: begin
          if (sample_tick && play) begin
            audio_data_reg  <= word_reg[DATA_W-1:16];
            audio_valid_reg <= 1'b1;
            state_reg       <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign flash_mem.read       = read_reg;
  assign flash_mem.address    = address_reg;
  assign flash_mem.byteenable = 4'hF;
  assign get_address          = get_address_reg;
  assign audio_data           = audio_data_reg;
  assign audio_valid          = audio_valid_reg;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Randomized bench for flash_sample_reader: Avalon slave + address counter models drive
// the DUT, a scoreboard queue holds the samples each delivered word should produce.
module tb_flash_sample_reader;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF;
  localparam int ADDR_RANGE = 32'h80000;

  logic              CLOCK_50;
  logic              reset_n;
  logic              play;
  logic              sample_tick;
  logic [ADDR_W-1:0] address_in;
  logic              get_address;
  logic [15:0]       audio_data;
  logic              audio_valid;

  flash_sample_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) flash_mem ();

  flash_sample_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .play        (play),
    .sample_tick (sample_tick),
    .address_in  (address_in),
    .get_address (get_address),
    .flash_mem   (flash_mem),
    .audio_data  (audio_data),
    .audio_valid (audio_valid)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  int errors = 0;
  int checks = 0;

  // scoreboard and high-level model state
  logic [15:0] exp_q[$];
  int  samples_ready = 0;
  bit  eff_at_edge = 0;
  bit  rdv_real_at_edge = 0;
  int  emitted = 0;
  int  get_cnt = 0;
  logic [15:0] last_audio = '0;

  // slave / stimulus state (main process only)
  int  seg_base = 0, seg_count = 0, delivered = 0;
  bit  rdv_real = 0, req_active = 0, outstanding = 0;
  int  wait_left = 0, planned_wait = 0, read_cycles = 0, lat_left = 0;
  int  cfg_wait = -1, cfg_lat = -1;
  bit  cfg_data_en = 0;
  logic [31:0] cfg_data = '0, last_word = '0;
  bit  stray_en = 0, stray_force = 0, tick_en = 0, tick_now = 0, play_rand = 0;
  int  tick_cnt = 0, ticks_issued = 0;
  logic [ADDR_W-1:0] prev_acc = '0;
  bit  wrap_seen = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  function automatic logic [ADDR_W-1:0] exp_addr();
    return ADDR_W'((seg_base + seg_count) % ADDR_RANGE);
  endfunction

  // One clock of environment: counter, Avalon slave, tick source, random play.
  task automatic step();
    @(negedge CLOCK_50);
    if (!reset_n) begin
      req_active = 0;
      outstanding = 0;
      rdv_real = 0;
      flash_mem.readdatavalid = 1'b0;
      flash_mem.waitrequest = 1'b0;
      sample_tick = 1'b0;
      return;
    end
    if (get_address) address_in = (address_in == LAST_ADDR) ? '0 : address_in + 1'b1;

    flash_mem.readdatavalid = 1'b0;
    rdv_real = 0;
    flash_mem.readdata = $urandom;
    if (flash_mem.read) begin
      if (!req_active) begin
        req_active = 1;
        planned_wait = (cfg_wait >= 0) ? cfg_wait : int'($urandom_range(0, 3));
        wait_left = planned_wait;
        read_cycles = 0;
      end
      read_cycles++;
      check_eq("flash_address", 32'(flash_mem.address), 32'(exp_addr()));
      if (wait_left > 0) begin
        flash_mem.waitrequest = 1'b1;
        wait_left--;
      end else begin
        flash_mem.waitrequest = 1'b0;
        req_active = 0;
        check_eq("read_cycles", 32'(read_cycles), 32'(planned_wait + 1));
        if (prev_acc == LAST_ADDR && flash_mem.address == '0) wrap_seen = 1;
        prev_acc = flash_mem.address;
        outstanding = 1;
        lat_left = (cfg_lat >= 0) ? cfg_lat : int'($urandom_range(1, 4));
      end
    end else begin
      flash_mem.waitrequest = 1'($urandom_range(0, 1));
      if (req_active) begin
        fail_now("read_dropped_before_accept");
        req_active = 0;
      end
      if (outstanding) begin
        lat_left--;
        if (lat_left <= 0) begin
          last_word = cfg_data_en ? cfg_data : $urandom;
          cfg_data_en = 0;
          flash_mem.readdata = last_word;
          flash_mem.readdatavalid = 1'b1;
          rdv_real = 1;
          exp_q.push_back(last_word[15:0]);
          exp_q.push_back(last_word[31:16]);
          outstanding = 0;
          seg_count++;
          delivered++;
          $display("word %0d: addr 0x%06h data 0x%08h", delivered, prev_acc, last_word);
        end
      end else if ((stray_en && $urandom_range(0, 7) == 0) || stray_force) begin
        flash_mem.readdata = 32'hFFFF_FFFF;
        flash_mem.readdatavalid = 1'b1;
      end
    end

    sample_tick = 1'b0;
    if (tick_now) begin
      sample_tick = 1'b1;
      tick_now = 0;
      ticks_issued++;
    end else if (tick_en) begin
      if (tick_cnt == 0) begin
        sample_tick = 1'b1;
        ticks_issued++;
        tick_cnt = $urandom_range(14, 24);
      end else begin
        tick_cnt--;
      end
    end
    if (play_rand && $urandom_range(0, 39) == 0) play = ~play;
  endtask

  // Reference model of which edges must produce a sample: a tick counts only while
  // play is high and a fetched word still has unplayed halves.
  initial begin
    forever begin
      @(posedge CLOCK_50);
      if (!reset_n) begin
        samples_ready = 0;
        eff_at_edge = 0;
        rdv_real_at_edge = 0;
      end else begin
        eff_at_edge = sample_tick && play && (samples_ready > 0);
        if (eff_at_edge) samples_ready--;
        rdv_real_at_edge = flash_mem.readdatavalid && rdv_real;
        if (rdv_real_at_edge) samples_ready += 2;
      end
    end
  end

  // Monitor: pops the scoreboard on every audio_valid, checks holds and get_address.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (!reset_n) begin
        exp_q.delete();
        last_audio = '0;
        emitted = 0;
      end else begin
        if (audio_valid || eff_at_edge)
          check_eq("audio_valid_timing", 32'(audio_valid), 32'(eff_at_edge));
        if (audio_valid) begin
          emitted++;
          if (exp_q.size() == 0) begin
            fail_now("sample_without_word");
          end else begin
            check_eq("sample", 32'(audio_data), 32'(exp_q.pop_front()));
          end
          $display("sample %0d: 0x%04h", emitted, audio_data);
          last_audio = audio_data;
        end else begin
          check_eq("audio_hold", 32'(audio_data), 32'(last_audio));
        end
        if (get_address || rdv_real_at_edge)
          check_eq("get_address", 32'(get_address), 32'(rdv_real_at_edge));
        if (get_address) get_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, t0, g0;
    bit ok;
    logic [15:0] frozen;

    reset_n = 1'b0;
    play = 1'b0;
    sample_tick = 1'b0;
    address_in = 23'h000010;
    flash_mem.waitrequest = 1'b0;
    flash_mem.readdata = '0;
    flash_mem.readdatavalid = 1'b0;
    seg_base = 32'h10;

    // reset values
    step(); step();
    check_eq("reset_read", 32'(flash_mem.read), 32'd0);
    check_eq("reset_address", 32'(flash_mem.address), 32'd0);
    check_eq("reset_get_address", 32'(get_address), 32'd0);
    check_eq("reset_audio_data", 32'(audio_data), 32'd0);
    check_eq("reset_audio_valid", 32'(audio_valid), 32'd0);
    check_eq("byteenable", 32'(flash_mem.byteenable), 32'hF);
    reset_n = 1'b1;
    step(); step();

    // basic fetch: 3 wait cycles, data 2 cycles after accept
    cfg_wait = 3;
    cfg_lat = 2;
    cfg_data = 32'hBEEF_1234;
    cfg_data_en = 1;
    play = 1'b1;
    step();
    check_eq("first_read_latency", 32'(flash_mem.read), 32'd1);
    check_eq("first_address", 32'(flash_mem.address), 32'h10);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin step(); ok = (delivered == 1); end
    if (!ok) fail_now("basic_fetch_timeout");
    step(); step();
    check_eq("basic_get_count", 32'(get_cnt), 32'd1);
    tick_now = 1;
    step(); step();
    check_eq("basic_lo_valid", 32'(audio_valid), 32'd1);
    check_eq("basic_lo_data", 32'(audio_data), 32'h1234);
    step(); step(); step();
    tick_now = 1;
    step(); step();
    check_eq("basic_hi_valid", 32'(audio_valid), 32'd1);
    check_eq("basic_hi_data", 32'(audio_data), 32'hBEEF);

    // a tick while the next word is still in flight is dropped
    cfg_wait = 0;
    cfg_lat = 4;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin step(); ok = outstanding; end
    if (!ok) fail_now("fetch2_accept_timeout");
    e0 = emitted;
    tick_now = 1;
    for (int i = 0; i < 8; i++) step();
    check_eq("tick_in_fetch_dropped", 32'(emitted), 32'(e0));
    check_eq("fetch2_words_ready", 32'(samples_ready), 32'd2);
    tick_now = 1;
    step(); step();
    check_eq("after_drop_valid", 32'(audio_valid), 32'd1);
    check_eq("after_drop_data", 32'(audio_data), 32'(last_word[15:0]));

    // randomized run: random waits, latencies, ticks, play toggling, stray readdatavalid
    cfg_wait = -1;
    cfg_lat = -1;
    stray_en = 1;
    tick_en = 1;
    play_rand = 1;
    for (int i = 0; i < 1500; i++) step();

    // pause between the two halves of a word
    play_rand = 0;
    play = 1'b1;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin step(); ok = (emitted % 2 == 1); end
    if (!ok) fail_now("pause_setup_timeout");
    step();
    play = 1'b0;
    frozen = audio_data;
    e0 = emitted;
    t0 = ticks_issued;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin step(); ok = (ticks_issued >= t0 + 5); end
    if (!ok) fail_now("pause_ticks_timeout");
    step(); step();
    check_eq("pause_no_output", 32'(emitted), 32'(e0));
    check_eq("pause_frozen", 32'(audio_data), 32'(frozen));
    play = 1'b1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin step(); ok = (emitted != e0); end
    if (!ok) fail_now("resume_timeout");
    step();
    check_eq("resume_one_sample", 32'(emitted), 32'(e0 + 1));

    // wrap continuity: counter presents 7FFFE, 7FFFF, 0, 1
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin step(); ok = (samples_ready == 2 && !outstanding); end
    if (!ok) fail_now("wrap_setup_timeout");
    address_in = 23'h7FFFE;
    seg_base = 32'h7FFFE;
    seg_count = 0;
    wrap_seen = 0;
    g0 = get_cnt;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin step(); ok = (seg_count >= 4); end
    if (!ok) fail_now("wrap_timeout");
    step(); step();
    check_eq("wrap_seen", 32'(wrap_seen), 32'd1);
    check_eq("wrap_get_count", 32'(get_cnt - g0), 32'(seg_count));

    // asynchronous reset while REQ is stalled
    cfg_wait = 12;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin step(); ok = (req_active && read_cycles >= 3); end
    if (!ok) fail_now("reset_setup_timeout");
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("async_reset_read", 32'(flash_mem.read), 32'd0);
    check_eq("async_reset_audio", 32'(audio_data), 32'd0);
    check_eq("async_reset_address", 32'(flash_mem.address), 32'd0);
    step(); step(); step();
    play = 1'b0;
    reset_n = 1'b1;
    seg_base = int'(address_in);
    seg_count = 0;
    cfg_wait = -1;
    stray_force = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("post_reset_get_address", 32'(get_address), 32'd0);
      check_eq("post_reset_read", 32'(flash_mem.read), 32'd0);
    end
    stray_force = 0;
    check_eq("post_reset_audio", 32'(audio_data), 32'd0);

    // recovery run, then drain with play low
    play = 1'b1;
    play_rand = 1;
    for (int i = 0; i < 400; i++) step();
    play_rand = 0;
    play = 1'b0;
    for (int i = 0; i < 60; i++) step();
    check_eq("get_count_total", 32'(get_cnt), 32'(delivered));
    check_eq("scoreboard_pending", 32'(exp_q.size()), 32'(samples_ready));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
